// File: rtl/average_readout.sv
// -----------------------------------------------------------------------------
// average_readout
//
// Readout end of the averaging accumulator. A LATCH strobe captures both
// channel sums, the pedestal word, the control sum and the pedestal-enable
// bit. One cycle later the sums are scaled to per-sample averages. Each
// average saturates to 16 bits and, optionally, has the pedestal removed with
// a clamp at zero. The result then leaves as a fixed frame of 16-bit words
// over a valid/ready bus.
//
// Frame: HEADER, r_1, r_2, {2'b0, CSUM}[, checksum]
//
// Build option:
//   READOUT_CHECKSUM_EN  defined   -> 5-word frame, last word = XOR of words 0..3
//                        undefined -> 4-word frame, no checksum logic
//
// Ports:
//   i_clk         system clock, all logic on posedge
//   i_reset       asynchronous active-high reset
//   i_latch       one-cycle strobe: capture inputs and start a frame
//   i_ped_en      1 = subtract pedestal from both averages
//   i_sum1/2      channel accumulated sums (SUM_W)
//   i_ped_in      pedestal word (ADC_W)
//   i_csum_in     control sum (ADC_W)
//   o_data_out    frame word, registered
//   o_data_valid  o_data_out holds a valid word
//   i_data_ready  consumer takes the word on valid && ready at posedge
//   o_busy        high from capture until the last word is accepted
//   o_overrun     sticky: LATCH arrived while busy
//   i_ovr_clr     synchronous clear of o_overrun (a new overrun wins)
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for LATCH; a LATCH here captures the inputs
// CALC  | one cycle: scale, saturate and pedestal-correct captured sums
// SEND  | stream words; first cycle loads HEADER, then advance on accept
// -----------------------------------------------------------------------------
module average_readout #(
    parameter int          SUM_W     = 32,
    parameter int          ADC_W     = 14,
    parameter int          AVG_SHIFT = 8,
    parameter logic [15:0] HEADER    = 16'hA5A5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_latch,
    input  logic             i_ped_en,
    input  logic [SUM_W-1:0] i_sum1,
    input  logic [SUM_W-1:0] i_sum2,
    input  logic [ADC_W-1:0] i_ped_in,
    input  logic [ADC_W-1:0] i_csum_in,
    output logic [15:0]      o_data_out,
    output logic             o_data_valid,
    input  logic             i_data_ready,
    output logic             o_busy,
    output logic             o_overrun,
    input  logic             i_ovr_clr
);

`ifdef READOUT_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Captured inputs
    logic [SUM_W-1:0] r_sum1;
    logic [SUM_W-1:0] r_sum2;
    logic [ADC_W-1:0] r_ped;
    logic [ADC_W-1:0] r_csum;
    logic             r_ped_en;

    // Computed results and streaming state
    logic [15:0] r_res1;
    logic [15:0] r_res2;
    logic [2:0]  r_idx;
    logic [15:0] r_data_out;
    logic        r_data_valid;
    logic        r_busy;
    logic        r_overrun;

    // Control strobes
    logic w_accept;
    logic w_last;
    logic w_capture;
    logic w_overrun_set;

    // Datapath
    logic [SUM_W-1:0] w_sh1;
    logic [SUM_W-1:0] w_sh2;
    logic [15:0]      w_avg1;
    logic [15:0]      w_avg2;
    logic [15:0]      w_ped16;
    logic [15:0]      w_csum16;
    logic [15:0]      w_res1;
    logic [15:0]      w_res2;
    logic [2:0]       w_sel;
    logic [15:0]      w_word;
`ifdef READOUT_CHECKSUM_EN
    logic [15:0]      w_cksum;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_accept = r_data_valid & i_data_ready;
    assign w_last   = w_accept && (r_idx == LAST_IDX);

    // -------------------------------------------------------------------------
    // Next-state and control strobes
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_capture     = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_latch) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                w_overrun_set = i_latch;
                w_state_next  = ST_SEND;
            end
            ST_SEND: begin
                // A LATCH on the last-accept edge is still treated as busy.
                w_overrun_set = i_latch;
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Scaling, saturation and pedestal correction
    // -------------------------------------------------------------------------
    assign w_sh1 = r_sum1 >> AVG_SHIFT;
    assign w_sh2 = r_sum2 >> AVG_SHIFT;

    // Any bit above the 16-bit window means the average does not fit.
    assign w_avg1 = (|w_sh1[SUM_W-1:16]) ? 16'hFFFF : w_sh1[15:0];
    assign w_avg2 = (|w_sh2[SUM_W-1:16]) ? 16'hFFFF : w_sh2[15:0];

    assign w_ped16  = 16'(r_ped);
    assign w_csum16 = 16'(r_csum);

    always_comb begin
        w_res1 = w_avg1;
        w_res2 = w_avg2;
        if (r_ped_en) begin
            w_res1 = (w_ped16 > w_avg1) ? 16'h0000 : (w_avg1 - w_ped16);
            w_res2 = (w_ped16 > w_avg2) ? 16'h0000 : (w_avg2 - w_ped16);
        end
    end

`ifdef READOUT_CHECKSUM_EN
    assign w_cksum = HEADER ^ r_res1 ^ r_res2 ^ w_csum16;
`endif

    // -------------------------------------------------------------------------
    // Word select: the first SEND cycle loads the current index. After that,
    // each accept loads the following word on the same edge, so a consumer
    // holding READY high sees no gaps.
    // -------------------------------------------------------------------------
    assign w_sel = r_data_valid ? (r_idx + 3'd1) : r_idx;

    always_comb begin
        w_word = 16'h0000;
        case (w_sel)
            3'd0:    w_word = HEADER;
            3'd1:    w_word = r_res1;
            3'd2:    w_word = r_res2;
            3'd3:    w_word = w_csum16;
`ifdef READOUT_CHECKSUM_EN
            3'd4:    w_word = w_cksum;
`endif
            default: w_word = 16'h0000;
        endcase
    end

    // -------------------------------------------------------------------------
    // Capture, result and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sum1       <= '0;
            r_sum2       <= '0;
            r_ped        <= '0;
            r_csum       <= '0;
            r_ped_en     <= 1'b0;
            r_res1       <= 16'h0000;
            r_res2       <= 16'h0000;
            r_idx        <= 3'd0;
            r_data_out   <= 16'h0000;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (w_capture) begin
                r_sum1   <= i_sum1;
                r_sum2   <= i_sum2;
                r_ped    <= i_ped_in;
                r_csum   <= i_csum_in;
                r_ped_en <= i_ped_en;
                r_busy   <= 1'b1;
            end

            if (r_state == ST_CALC) begin
                r_res1 <= w_res1;
                r_res2 <= w_res2;
                r_idx  <= 3'd0;
            end

            if (r_state == ST_SEND) begin
                if (w_last) begin
                    r_data_out   <= 16'h0000;
                    r_data_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end else if (!r_data_valid || i_data_ready) begin
                    r_data_out   <= w_word;
                    r_data_valid <= 1'b1;
                    r_idx        <= w_sel;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
    assign o_busy       = r_busy;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_average_readout.sv
// -----------------------------------------------------------------------------
// tb_average_readout
//
// Self-checking bench for average_readout. Inputs are driven and outputs are
// sampled on the falling edge of the clock. Expected frames come from a
// reference model written with plain integer arithmetic: divide, min and
// subtract-with-floor. Frame length follows READOUT_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_average_readout;

`ifdef READOUT_CHECKSUM_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif
    localparam logic [15:0] HDR = 16'hA5A5;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_latch;
    logic        i_ped_en;
    logic [31:0] i_sum1;
    logic [31:0] i_sum2;
    logic [13:0] i_ped_in;
    logic [13:0] i_csum_in;
    logic [15:0] o_data_out;
    logic        o_data_valid;
    logic        i_data_ready;
    logic        o_busy;
    logic        o_overrun;
    logic        i_ovr_clr;

    always #5 i_clk = ~i_clk;

    average_readout dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_latch      (i_latch),
        .i_ped_en     (i_ped_en),
        .i_sum1       (i_sum1),
        .i_sum2       (i_sum2),
        .i_ped_in     (i_ped_in),
        .i_csum_in    (i_csum_in),
        .o_data_out   (o_data_out),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun),
        .i_ovr_clr    (i_ovr_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] q_words[$];
    logic [16:0] q_trace[$];
    logic [15:0] exp_q[$];
    int          g_first_valid;
    bit          g_timeout;

    // Average of 256 samples, saturated to 16 bits, optional pedestal floor at 0.
    function automatic logic [15:0] ref_avg(input logic [31:0] s, input logic [13:0] p,
                                            input logic pe);
        longint a;
        longint ped;
        a   = longint'(s) / 256;
        ped = longint'(p);
        if (a > 65535) a = 65535;
        if (pe) a = (ped > a) ? 0 : a - ped;
        return a[15:0];
    endfunction

    task automatic build_expected(input logic [31:0] s1, input logic [31:0] s2,
                                  input logic [13:0] ped, input logic [13:0] csum,
                                  input logic pe);
        logic [15:0] x;
        exp_q.delete();
        exp_q.push_back(HDR);
        exp_q.push_back(ref_avg(s1, ped, pe));
        exp_q.push_back(ref_avg(s2, ped, pe));
        exp_q.push_back({2'b00, csum});
        if (FRAME_LEN == 5) begin
            x = 16'h0000;
            foreach (exp_q[i]) x = x ^ exp_q[i];
            exp_q.push_back(x);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the capture edge.
    task automatic start_frame(input logic [31:0] s1, input logic [31:0] s2,
                               input logic [13:0] ped, input logic [13:0] csum,
                               input logic pe);
        i_sum1    = s1;
        i_sum2    = s2;
        i_ped_in  = ped;
        i_csum_in = csum;
        i_ped_en  = pe;
        i_latch   = 1'b1;
        @(negedge i_clk);
        i_latch   = 1'b0;
        i_sum1    = $urandom;
        i_sum2    = $urandom;
        i_ped_in  = 14'($urandom);
        i_csum_in = 14'($urandom);
        i_ped_en  = 1'($urandom);
    endtask

    // Drives READY from rdy_mask (bit per cycle, 1 after 32 cycles). Optionally
    // pulses LATCH / OVR_CLR at given cycles, and records accepted words plus a
    // per-cycle {valid, data} trace. It stops after the edge that takes the
    // FRAME_LEN-th word, or after a cycle budget.
    task automatic collect(input logic [31:0] rdy_mask, input int latch_at, input int clr_at);
        bit done;
        done = 1'b0;
        q_words.delete();
        q_trace.delete();
        g_first_valid = -1;
        g_timeout     = 1'b0;
        for (int it = 0; it < 200; it++) begin
            q_trace.push_back({o_data_valid, o_data_out});
            if (o_data_valid && g_first_valid < 0) g_first_valid = it;
            i_data_ready = (it < 32) ? rdy_mask[it] : 1'b1;
            i_latch      = (it == latch_at);
            i_ovr_clr    = (it == clr_at);
            if (it == latch_at) begin
                i_sum1    = $urandom;
                i_sum2    = $urandom;
                i_ped_in  = 14'($urandom);
                i_csum_in = 14'($urandom);
                i_ped_en  = 1'($urandom);
            end
            if (o_data_valid && i_data_ready) q_words.push_back(o_data_out);
            @(negedge i_clk);
            i_latch   = 1'b0;
            i_ovr_clr = 1'b0;
            if (q_words.size() >= FRAME_LEN) begin
                done = 1'b1;
                break;
            end
        end
        i_data_ready = 1'b0;
        if (!done) g_timeout = 1'b1;
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (3) @(negedge i_clk);
        n_tests++;
        if (o_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b want 0", o_data_valid);
        end
        n_tests++;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0", o_busy);
        end
        n_tests++;
        if (o_overrun !== 1'b0) begin
            n_fail++; $display("FAIL reset_overrun got %b want 0", o_overrun);
        end
        n_tests++;
        if (o_data_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data got %h want 0000", o_data_out);
        end
    endtask

    task automatic test_nominal;
        logic [15:0] nom[5];
        nom[0] = 16'hA5A5; nom[1] = 16'h039C; nom[2] = 16'h019C;
        nom[3] = 16'h0123; nom[4] = 16'hA686;
        start_frame(32'h0004_0000, 32'h0002_0000, 14'd100, 14'h0123, 1'b1);
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL nominal_busy_after_latch got %b want 1", o_busy);
        end
        collect(32'hFFFF_FFFF, -1, -1);
        n_tests++;
        if (g_first_valid != 2) begin
            n_fail++; $display("FAIL nominal_latency got %0d want 2", g_first_valid);
        end
        n_tests++;
        if (g_timeout || q_words.size() != FRAME_LEN) begin
            n_fail++; $display("FAIL nominal_len got %0d want %0d", q_words.size(), FRAME_LEN);
        end
        for (int i = 0; i < FRAME_LEN && i < q_words.size(); i++) begin
            n_tests++;
            if (q_words[i] !== nom[i]) begin
                n_fail++; $display("FAIL nominal_word%0d got %h want %h", i, q_words[i], nom[i]);
            end
        end
        // Full-rate: words back to back with READY held high.
        n_tests++;
        if (q_trace.size() < 2 + FRAME_LEN || q_trace[2 + FRAME_LEN - 1][16] !== 1'b1) begin
            n_fail++; $display("FAIL nominal_no_bubbles got %0d want %0d", q_trace.size(), 2 + FRAME_LEN);
        end
        n_tests++;
        if (o_busy !== 1'b0 || o_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL nominal_end got busy=%b valid=%b want 0 0", o_busy, o_data_valid);
        end
    endtask

    task automatic test_saturation;
        logic [31:0] s1[4];
        logic [31:0] s2[4];
        logic        pe[4];
        logic [15:0] w1[4];
        logic [15:0] w2[4];
        s1[0] = 32'hFFFF_FFFF; s2[0] = 32'h0000_0100; pe[0] = 1'b1; w1[0] = 16'hFFFA; w2[0] = 16'h0000;
        s1[1] = 32'hFFFF_FFFF; s2[1] = 32'h0000_0100; pe[1] = 1'b0; w1[1] = 16'hFFFF; w2[1] = 16'h0001;
        s1[2] = 32'h00FF_FFFF; s2[2] = 32'h0000_0500; pe[2] = 1'b1; w1[2] = 16'hFFFA; w2[2] = 16'h0000;
        s1[3] = 32'h0100_0000; s2[3] = 32'h0000_05FF; pe[3] = 1'b0; w1[3] = 16'hFFFF; w2[3] = 16'h0005;
        for (int k = 0; k < 4; k++) begin
            build_expected(s1[k], s2[k], 14'd5, 14'h3FFF, pe[k]);
            start_frame(s1[k], s2[k], 14'd5, 14'h3FFF, pe[k]);
            collect(32'hFFFF_FFFF, -1, -1);
            n_tests++;
            if (g_timeout || q_words.size() < 3) begin
                n_fail++; $display("FAIL sat%0d_len got %0d want %0d", k, q_words.size(), FRAME_LEN);
            end else begin
                n_tests++;
                if (q_words[1] !== w1[k]) begin
                    n_fail++; $display("FAIL sat%0d_r1 got %h want %h", k, q_words[1], w1[k]);
                end
                n_tests++;
                if (q_words[2] !== w2[k]) begin
                    n_fail++; $display("FAIL sat%0d_r2 got %h want %h", k, q_words[2], w2[k]);
                end
                for (int i = 0; i < FRAME_LEN && i < q_words.size(); i++) begin
                    n_tests++;
                    if (q_words[i] !== exp_q[i]) begin
                        n_fail++; $display("FAIL sat%0d_word%0d got %h want %h", k, i, q_words[i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure;
        build_expected(32'h0004_0000, 32'h0002_0000, 14'd100, 14'h0123, 1'b1);
        start_frame(32'h0004_0000, 32'h0002_0000, 14'd100, 14'h0123, 1'b1);
        collect(32'hFFFF_FFC7, -1, -1);
        for (int c = 3; c <= 6; c++) begin
            n_tests++;
            if (c >= q_trace.size() || q_trace[c] !== {1'b1, 16'h039C}) begin
                n_fail++;
                $display("FAIL bp_hold_cycle%0d got %h want 1039c", c,
                         (c < q_trace.size()) ? q_trace[c] : 17'h0);
            end
        end
        n_tests++;
        if (g_timeout || q_words.size() != FRAME_LEN) begin
            n_fail++; $display("FAIL bp_len got %0d want %0d", q_words.size(), FRAME_LEN);
        end
        for (int i = 0; i < FRAME_LEN && i < q_words.size(); i++) begin
            n_tests++;
            if (q_words[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_word%0d got %h want %h", i, q_words[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overrun;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [13:0] p;
        logic [13:0] c;
        for (int k = 0; k < 2; k++) begin
            s1 = $urandom; s2 = $urandom_range(0, 32'h00FF_FFFF);
            p  = 14'($urandom); c = 14'($urandom);
            build_expected(s1, s2, p, c, 1'b1);
            start_frame(s1, s2, p, c, 1'b1);
            // k=0: LATCH during SEND; k=1: same LATCH with a simultaneous OVR_CLR.
            collect(32'hFFFF_FFFF, 3, (k == 1) ? 3 : -1);
            n_tests++;
            if (o_overrun !== 1'b1) begin
                n_fail++; $display("FAIL ovr%0d_set got %b want 1", k, o_overrun);
            end
            n_tests++;
            if (g_timeout || q_words.size() != FRAME_LEN) begin
                n_fail++; $display("FAIL ovr%0d_len got %0d want %0d", k, q_words.size(), FRAME_LEN);
            end
            for (int i = 0; i < FRAME_LEN && i < q_words.size(); i++) begin
                n_tests++;
                if (q_words[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL ovr%0d_word%0d got %h want %h", k, i, q_words[i], exp_q[i]);
                end
            end
            i_ovr_clr = 1'b1;
            @(negedge i_clk);
            i_ovr_clr = 1'b0;
            n_tests++;
            if (o_overrun !== 1'b0) begin
                n_fail++; $display("FAIL ovr%0d_clear got %b want 0", k, o_overrun);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [13:0] p;
        logic [13:0] c;
        s1 = $urandom; s2 = $urandom; p = 14'($urandom); c = 14'($urandom);
        build_expected(s1, s2, p, c, 1'b0);
        start_frame(s1, s2, p, c, 1'b0);
        // LATCH lands on the same edge that takes the last word.
        collect(32'hFFFF_FFFF, FRAME_LEN + 1, -1);
        n_tests++;
        if (o_busy !== 1'b0 || o_overrun !== 1'b1) begin
            n_fail++; $display("FAIL b2b_last_edge_latch got busy=%b ovr=%b want 0 1", o_busy, o_overrun);
        end
        for (int i = 0; i < FRAME_LEN && i < q_words.size(); i++) begin
            n_tests++;
            if (q_words[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_a_word%0d got %h want %h", i, q_words[i], exp_q[i]);
            end
        end
        // LATCH on the very next cycle must start a new frame.
        s1 = $urandom; s2 = $urandom_range(0, 32'h0FFF_FFFF); p = 14'($urandom); c = 14'($urandom);
        build_expected(s1, s2, p, c, 1'b1);
        start_frame(s1, s2, p, c, 1'b1);
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_restart_busy got %b want 1", o_busy);
        end
        collect(32'hFFFF_FFFF, -1, -1);
        n_tests++;
        if (g_timeout || q_words.size() != FRAME_LEN) begin
            n_fail++; $display("FAIL b2b_b_len got %0d want %0d", q_words.size(), FRAME_LEN);
        end
        for (int i = 0; i < FRAME_LEN && i < q_words.size(); i++) begin
            n_tests++;
            if (q_words[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_b_word%0d got %h want %h", i, q_words[i], exp_q[i]);
            end
        end
        i_ovr_clr = 1'b1;
        @(negedge i_clk);
        i_ovr_clr = 1'b0;
    endtask

    task automatic test_reset_midframe;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [13:0] p;
        logic [13:0] c;
        s1 = 32'h0012_3400; s2 = 32'h0000_FF00; p = 14'd7; c = 14'h2AAA;
        build_expected(s1, s2, p, c, 1'b1);
        start_frame(s1, s2, p, c, 1'b1);
        i_data_ready = 1'b1;
        i_latch = 1'b1;
        @(negedge i_clk);
        i_latch = 1'b0;
        repeat (3) @(negedge i_clk);
        n_tests++;
        if (o_data_valid !== 1'b1 || o_data_out !== exp_q[2]) begin
            n_fail++; $display("FAIL rstmid_word2 got v=%b %h want v=1 %h", o_data_valid, o_data_out, exp_q[2]);
        end
        #2 i_reset = 1'b1;
        #1;
        n_tests++;
        if (o_data_valid !== 1'b0 || o_busy !== 1'b0 || o_overrun !== 1'b0 || o_data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmid_async got v=%b busy=%b ovr=%b data=%h want 0 0 0 0000",
                     o_data_valid, o_busy, o_overrun, o_data_out);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (4) @(negedge i_clk);
        n_tests++;
        if (o_data_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_no_resume got v=%b busy=%b want 0 0", o_data_valid, o_busy);
        end
        i_data_ready = 1'b0;
        s1 = 32'h0000_8000; s2 = 32'h7FFF_0000; p = 14'd0; c = 14'h0001;
        build_expected(s1, s2, p, c, 1'b1);
        start_frame(s1, s2, p, c, 1'b1);
        collect(32'hFFFF_FFFF, -1, -1);
        n_tests++;
        if (g_timeout || q_words.size() != FRAME_LEN) begin
            n_fail++; $display("FAIL rstmid_len got %0d want %0d", q_words.size(), FRAME_LEN);
        end
        for (int i = 0; i < FRAME_LEN && i < q_words.size(); i++) begin
            n_tests++;
            if (q_words[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rstmid_word%0d got %h want %h", i, q_words[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [13:0] p;
        logic [13:0] c;
        logic        pe;
        for (int k = 0; k < 30; k++) begin
            s1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 32'h00FF_FFFF);
            s2 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 32'h0003_FFFF);
            p  = 14'($urandom);
            c  = 14'($urandom);
            pe = 1'($urandom);
            build_expected(s1, s2, p, c, pe);
            start_frame(s1, s2, p, c, pe);
            collect($urandom, -1, -1);
            n_tests++;
            if (g_timeout || q_words.size() != FRAME_LEN || g_first_valid != 2) begin
                n_fail++;
                $display("FAIL rand%0d_frame got len=%0d first=%0d want len=%0d first=2",
                         k, q_words.size(), g_first_valid, FRAME_LEN);
            end
            for (int i = 0; i < FRAME_LEN && i < q_words.size(); i++) begin
                n_tests++;
                if (q_words[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand%0d_word%0d got %h want %h", k, i, q_words[i], exp_q[i]);
                end
            end
            n_tests++;
            if (o_busy !== 1'b0 || o_overrun !== 1'b0) begin
                n_fail++; $display("FAIL rand%0d_end got busy=%b ovr=%b want 0 0", k, o_busy, o_overrun);
            end
        end
    endtask

    initial begin
        i_reset      = 1'b1;
        i_latch      = 1'b0;
        i_ped_en     = 1'b0;
        i_sum1       = '0;
        i_sum2       = '0;
        i_ped_in     = '0;
        i_csum_in    = '0;
        i_data_ready = 1'b0;
        i_ovr_clr    = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_nominal();
        test_saturation();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/average_readout.md
Name: average_readout

Overview:
- Readout end of the averaging accumulator.
- On a LATCH strobe it captures the two channel sums, the pedestal word and the control sum.
- It scales the sums to per-sample averages, optionally subtracts the pedestal, and streams the result as a fixed 16-bit word frame to the MCU-side bus.
- The MCU-side bus uses a valid/ready handshake.

Parameters:
- SUM_W, 32: width of SUM1/SUM2 inputs (matches `SUMMER).
- ADC_W, 14: width of PED_IN/CSUM_IN (matches `ADC_WIDHT).
- AVG_SHIFT, 8: log2 of samples per accumulation; average = sum >> AVG_SHIFT.
- HEADER, 16'hA5A5: first word of every frame.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RESET  in  1  asynchronous active-high reset.
- LATCH  in  1  one-cycle strobe: capture inputs and start a frame.
- PED_EN  in  1  1 = subtract pedestal (driven from MODE pedestal bit).
- SUM1  in  SUM_W  channel 1 accumulated sum.
- SUM2  in  SUM_W  channel 2 accumulated sum.
- PED_IN  in  ADC_W  pedestal word.
- CSUM_IN  in  ADC_W  control sum.
- DATA_OUT  out  16  frame word.
- DATA_VALID  out  1  DATA_OUT holds a valid word.
- DATA_READY  in  1  consumer accepts the word when VALID&&READY at a posedge.
- BUSY  out  1  high from capture until the last word is accepted.
- OVERRUN  out  1  sticky; set when LATCH arrives while BUSY.
- OVR_CLR  in  1  synchronous clear of OVERRUN.

Behaviour:
- Reset (async, RESET=1) values:
  - state=IDLE; DATA_OUT=0, DATA_VALID=0, BUSY=0, OVERRUN=0.
  - All capture registers are 0.
- State machine: IDLE -> CALC -> SEND -> IDLE.
- IDLE, LATCH=1 at edge n:
  - Register SUM1, SUM2, PED_IN, CSUM_IN and PED_EN.
  - BUSY=1 from n+1; go to CALC.
- CALC, one cycle:
  - a_k = captured SUMk >> AVG_SHIFT.
  - Saturate a_k to 16'hFFFF if any higher bit is set.
  - If PED_EN: r_k = a_k - zero-extended PED; clamp to 0 if PED > a_k.
  - Else r_k = a_k.
  - Load word index 0 and go to SEND.
- SEND:
  - Word order: 0 HEADER, 1 r_1, 2 r_2, 3 {2'b0, CSUM}, 4 checksum (see Optional Feature).
  - First word is valid at edge n+2, i.e. LATCH-to-first-VALID latency is 2 cycles.
  - DATA_OUT/DATA_VALID are registered.
  - While VALID && !READY, DATA_OUT is held stable.
  - On VALID && READY, advance the index; the next word is presented in the same edge, so there are no bubbles.
  - Full-rate transfer when READY is held high.
- Last word accepted:
  - DATA_VALID=0, BUSY=0, back to IDLE on that edge.
  - A LATCH on the very next cycle is accepted normally.
- LATCH while BUSY (CALC or SEND): ignored.
  - The frame in flight is unaffected; captured values are not overwritten.
  - OVERRUN=1.
- LATCH in the same cycle as the last-word acceptance counts as BUSY: dropped and OVERRUN set.
- OVERRUN: OVR_CLR clears it.
  - If OVR_CLR and a new overrun occur in the same cycle, set wins.
- RESET asserted mid-frame: frame is aborted immediately and all outputs return to reset values.
  - No partial frame resumes after reset release.
- Inputs SUM*/PED_IN/CSUM_IN may change freely after the capture edge; only captured copies are used.

Optional Feature:
- Macro: READOUT_CHECKSUM_EN.
- Defined:
  - Frame is 5 words; word 4 = XOR of words 0..3.
  - BUSY drops after word 4 is accepted.
- Undefined:
  - Frame is 4 words (indices 0..3).
  - No checksum logic.
  - BUSY drops after word 3 is accepted.

Test Plan:
- Reset then idle: RESET pulse, no LATCH -> DATA_VALID=0, BUSY=0, OVERRUN=0, DATA_OUT=0.
- Nominal frame, checksum enabled:
  - Inputs: SUM1=32'h0004_0000, SUM2=32'h0002_0000, PED_IN=100, CSUM_IN=14'h0123, PED_EN=1, READY=1.
  - LATCH -> VALID at LATCH+2.
  - Words: A5A5, 039C, 019C, 0123, A686; BUSY low after the 5th word.
- Saturation/clamp, PED_EN=1:
  - SUM1=32'hFFFF_FFFF gives r_1=FFFF-PED.
  - SUM2=32'h0000_0100 (a=1) with PED_IN=5 gives r_2=0000.
  - With PED_EN=0: r_1=FFFF, r_2=0001.
- Backpressure: READY low for 3 cycles on word 1 -> DATA_OUT stays 039C, VALID stays high, no word skipped or duplicated.
- Overrun:
  - LATCH during SEND -> OVERRUN=1 and the frame content is unchanged.
  - OVR_CLR -> OVERRUN=0.
  - Simultaneous OVR_CLR and busy LATCH -> OVERRUN stays 1.
- Reset mid-frame, plus no-checksum build:
  - RESET during word 2 -> VALID=0, BUSY=0.
  - Next LATCH restarts at HEADER.
  - Build without READOUT_CHECKSUM_EN -> frame is exactly 4 words.
